sdram_arbiter: RTL

- Round-robin arbiter that shares the single SDRAM controller port between NUM_MASTERS requesters (CPU I/D caches, blitter, VGA fetch, ...).
- Latches the winning master's transaction, presents it on the controller request interface and holds it until the controller accepts it.
- Returns an acknowledge to the winner.
- Decodes the controller's master-tagged read-valid/complete pulses back to per-master strobes.

---
 rtl/sdram_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port among NUM_MASTERS requesters.
// Registers the winner's transaction until accepted and decodes tagged read-return strobes.
module sdram_arbiter #(
    parameter int unsigned NUM_MASTERS = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    m_request,
    input  logic [NUM_MASTERS-1:0]    m_write,
    input  logic [26*NUM_MASTERS-1:0] m_address,
    input  logic [32*NUM_MASTERS-1:0] m_wdata,
    input  logic [4*NUM_MASTERS-1:0]  m_byte_en,
    input  logic [NUM_MASTERS-1:0]    m_burst,
    output logic [NUM_MASTERS-1:0]    m_ack,
    output logic [NUM_MASTERS-1:0]    m_rvalid,
    output logic [NUM_MASTERS-1:0]    m_complete,
    output logic [31:0]               m_rdata,
    output logic                      sdram_request,
    output logic [3:0]                sdram_master,
    output logic                      sdram_write,
    output logic [25:0]               sdram_address,
    output logic [31:0]               sdram_wdata,
    output logic [3:0]                sdram_byte_en,
    output logic                      sdram_burst,
    input  logic [31:0]               sdram_rdata,
    input  logic [3:0]                sdram_valid,
    input  logic [3:0]                sdram_complete,
    input  logic                      sdram_ready
);

    localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StAck
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] winner_q, winner_d;

    logic [NUM_MASTERS-1:0] m_ack_q, m_ack_d;

    logic        sdram_request_q, sdram_request_d;
    logic [3:0]  sdram_master_q, sdram_master_d;
    logic        sdram_write_q, sdram_write_d;
    logic [25:0] sdram_address_q, sdram_address_d;
    logic [31:0] sdram_wdata_q, sdram_wdata_d;
    logic [3:0]  sdram_byte_en_q, sdram_byte_en_d;
    logic        sdram_burst_q, sdram_burst_d;

    logic            sel_found;
    logic [IdxW-1:0] sel_idx;
    logic            sel_write;
    logic [25:0]     sel_address;
    logic [31:0]     sel_wdata;
    logic [3:0]      sel_byte_en;
    logic            sel_burst;

    // (base + off) modulo NUM_MASTERS, for base < NUM_MASTERS and off <= NUM_MASTERS
    function automatic logic [IdxW-1:0] wrap_idx(input int unsigned base,
                                                 input int unsigned off);
        int unsigned sum;
        sum = base + off;
        if (sum >= NUM_MASTERS) begin
            sum = sum - NUM_MASTERS;
        end
        return IdxW'(sum);
    endfunction

    // First requesting master at or after rr_ptr, wrapping around
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned off = 0; off < NUM_MASTERS; off++) begin
            if (!sel_found && m_request[wrap_idx(32'(rr_ptr_q), off)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_idx(32'(rr_ptr_q), off);
            end
        end
    end

    always_comb begin
        sel_write   = 1'b0;
        sel_address = '0;
        sel_wdata   = '0;
        sel_byte_en = '0;
        sel_burst   = 1'b0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (sel_idx == IdxW'(i)) begin
                sel_write   = m_write[i];
                sel_address = m_address[26*i +: 26];
                sel_wdata   = m_wdata[32*i +: 32];
                sel_byte_en = m_byte_en[4*i +: 4];
                sel_burst   = m_burst[i];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        winner_d        = winner_q;
        m_ack_d         = '0;
        sdram_request_d = sdram_request_q;
        sdram_master_d  = sdram_master_q;
        sdram_write_d   = sdram_write_q;
        sdram_address_d = sdram_address_q;
        sdram_wdata_d   = sdram_wdata_q;
        sdram_byte_en_d = sdram_byte_en_q;
        sdram_burst_d   = sdram_burst_q;

        case (state_q)
            StIdle: begin
                if (sel_found) begin
                    winner_d        = sel_idx;
                    sdram_request_d = 1'b1;
                    sdram_master_d  = 4'(sel_idx) + 4'd1;
                    sdram_write_d   = sel_write;
                    sdram_address_d = sel_address;
                    sdram_wdata_d   = sel_wdata;
                    sdram_byte_en_d = sel_byte_en;
                    sdram_burst_d   = sel_burst;
                    state_d         = StIssue;
                end
            end
            StIssue: begin
                // Transaction fields stay frozen until the controller takes it
                if (sdram_request_q && sdram_ready) begin
                    sdram_request_d   = 1'b0;
                    m_ack_d[winner_q] = 1'b1;
                    rr_ptr_d          = wrap_idx(32'(winner_q), 1);
                    state_d           = StAck;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            rr_ptr_q        <= '0;
            winner_q        <= '0;
            m_ack_q         <= '0;
            sdram_request_q <= 1'b0;
            sdram_master_q  <= '0;
            sdram_write_q   <= 1'b0;
            sdram_address_q <= '0;
            sdram_wdata_q   <= '0;
            sdram_byte_en_q <= '0;
            sdram_burst_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            winner_q        <= winner_d;
            m_ack_q         <= m_ack_d;
            sdram_request_q <= sdram_request_d;
            sdram_master_q  <= sdram_master_d;
            sdram_write_q   <= sdram_write_d;
            sdram_address_q <= sdram_address_d;
            sdram_wdata_q   <= sdram_wdata_d;
            sdram_byte_en_q <= sdram_byte_en_d;
            sdram_burst_q   <= sdram_burst_d;
        end
    end

    assign m_ack         = m_ack_q;
    assign sdram_request = sdram_request_q;
    assign sdram_master  = sdram_master_q;
    assign sdram_write   = sdram_write_q;
    assign sdram_address = sdram_address_q;
    assign sdram_wdata   = sdram_wdata_q;
    assign sdram_byte_en = sdram_byte_en_q;
    assign sdram_burst   = sdram_burst_q;

    // Return path is purely combinational so it can overlap issue of the next transaction
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_ret
        assign m_rvalid[i]   = (sdram_valid == 4'(i + 1));
        assign m_complete[i] = (sdram_complete == 4'(i + 1));
    end

    assign m_rdata = sdram_rdata;

endmodule
